// File: rtl/cu_pkg.sv
// ============================================================================
//  Module      : cu_pkg
//  Description : Shared types and constants for the control_unit block:
//                FSM state encoding, instruction opcodes, ALU function
//                selects and the opcode-to-state decode helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cu_pkg;

  // FSM state encoding; the codes are visible on state_out.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  // Instruction opcodes carried in IR[15:12].
  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  // ALU function selects driven on ALU_s0.
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Execution state reached from DECODE for a given opcode.
  // Opcodes 6..15 are unassigned and execute as a no-op.
  function automatic state_t decode_op(input logic [3:0] op);
    state_t st;
    case (op)
      OP_NOOP:  st = S_NOOP;
      OP_STORE: st = S_STORE;
      OP_LOAD:  st = S_LOAD_A;
      OP_ADD:   st = S_ADD;
      OP_SUB:   st = S_SUB;
      OP_HALT:  st = S_HALT;
      default:  st = S_NOOP;
    endcase
    return st;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_counter.sv
// ============================================================================
//  Module      : pc_counter
//  Description : 8-bit program counter with synchronous clear and increment.
//                Wraps naturally from 255 to 0. Asynchronous active-low reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       up,
  output logic [7:0] pc
);

  logic [7:0] r_pc;

  // Counter register: clear wins over increment; the 8-bit add wraps 255->0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= 8'd0;
    end else if (clr) begin
      r_pc <= 8'd0;
    end else if (up) begin
      r_pc <= r_pc + 8'd1;
    end
  end

  assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
//  Module      : control_unit
//  Description : Multi-cycle instruction sequencer. Fetches a 16-bit
//                instruction at pc_out, decodes IR[15:12] and drives Moore
//                datapath controls (data memory, register file, ALU).
//                Optional feature macro: CU_SINGLE_STEP_EN adds a 'step'
//                input that gates FETCH so one pulse runs one instruction.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module control_unit
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
`ifdef CU_SINGLE_STEP_EN
  input  logic        step,
`endif
  input  logic [15:0] instr_in,
  output logic [7:0]  pc_out,
  output logic [15:0] IR_out,
  output logic [7:0]  D_addr,
  output logic        D_wr,
  output logic        RF_sel,
  output logic        RF_W_en,
  output logic [3:0]  WriteAddr,
  output logic [3:0]  rdAddrA,
  output logic [3:0]  rdAddrB,
  output logic [2:0]  ALU_s0,
  output logic [3:0]  state_out,
  output logic        halted
);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_ir;
  logic        w_fetch_go;
  logic        w_pc_clr;

  logic [7:0]  w_d_addr;
  logic        w_d_wr;
  logic        w_rf_sel;
  logic        w_rf_w_en;
  logic [3:0]  w_write_addr;
  logic [3:0]  w_rd_addr_a;
  logic [3:0]  w_rd_addr_b;
  logic [2:0]  w_alu_s0;

  // FETCH completes (IR load + pc increment) only when allowed to advance.
`ifdef CU_SINGLE_STEP_EN
  assign w_fetch_go = (r_state == S_FETCH) && step;
`else
  assign w_fetch_go = (r_state == S_FETCH);
`endif

  assign w_pc_clr = (r_state == S_INIT);

  pc_counter u_pc_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_pc_clr),
    .up    (w_fetch_go),
    .pc    (pc_out)
  );

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Instruction register: cleared in INIT, loaded only when FETCH advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= 16'd0;
    end else if (r_state == S_INIT) begin
      r_ir <= 16'd0;
    end else if (w_fetch_go) begin
      r_ir <= instr_in;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_INIT:   w_next_state = S_FETCH;
      S_FETCH:  w_next_state = w_fetch_go ? S_DECODE : S_FETCH;
      S_DECODE: w_next_state = decode_op(r_ir[15:12]);
      S_LOAD_A: w_next_state = S_LOAD_B;
      S_NOOP,
      S_STORE,
      S_LOAD_B,
      S_ADD,
      S_SUB:    w_next_state = S_FETCH;
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_INIT;
    endcase
  end

  // Moore datapath decode. Address fields always follow IR so they are
  // stable ahead of the execute state; only the enables depend on state.
  // Outside execute states D_addr shows the field the current opcode uses.
  always_comb begin
    w_d_addr     = (r_ir[15:12] == OP_LOAD) ? r_ir[11:4] : r_ir[7:0];
    w_write_addr = r_ir[3:0];
    w_rd_addr_a  = r_ir[11:8];
    w_rd_addr_b  = r_ir[7:4];
    w_d_wr       = 1'b0;
    w_rf_sel     = 1'b0;
    w_rf_w_en    = 1'b0;
    w_alu_s0     = ALU_PASS;
    case (r_state)
      S_STORE: begin
        w_d_addr = r_ir[7:0];
        w_d_wr   = 1'b1;
      end
      S_LOAD_A: begin
        // Memory read latency cycle: select memory path, hold write off.
        w_d_addr = r_ir[11:4];
        w_rf_sel = 1'b1;
      end
      S_LOAD_B: begin
        w_d_addr  = r_ir[11:4];
        w_rf_sel  = 1'b1;
        w_rf_w_en = 1'b1;
      end
      S_ADD: begin
        w_rf_w_en = 1'b1;
        w_alu_s0  = ALU_ADD;
      end
      S_SUB: begin
        w_rf_w_en = 1'b1;
        w_alu_s0  = ALU_SUB;
      end
      default: begin
      end
    endcase
  end

  assign IR_out    = r_ir;
  assign D_addr    = w_d_addr;
  assign D_wr      = w_d_wr;
  assign RF_sel    = w_rf_sel;
  assign RF_W_en   = w_rf_w_en;
  assign WriteAddr = w_write_addr;
  assign rdAddrA   = w_rd_addr_a;
  assign rdAddrB   = w_rd_addr_b;
  assign ALU_s0    = w_alu_s0;
  assign state_out = r_state;
  assign halted    = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  Single system clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  Asynchronous, active-low reset.
REQ-003 instr_in  input  16  Instruction word from instruction memory at address pc_out: [15:12] opcode, [11:0] operand field.
REQ-004 pc_out  output  8  Program counter; this is the instruction memory address.
REQ-005 IR_out  output  16  Instruction register, for monitoring.
REQ-006 D_addr  output  8  Datapath data-memory address.
REQ-007 D_wr  output  1  Datapath data-memory write enable.
REQ-008 RF_sel  output  1  Register-file write mux select: 0 = ALU, 1 = data memory.
REQ-009 RF_W_en  output  1  Register-file write enable.
REQ-010 WriteAddr, rdAddrA, rdAddrB  output  4 each  Register-file addresses.
REQ-011 ALU_s0  output  3  ALU function: 0 = pass A, 1 = add, 2 = sub.
REQ-012 state_out  output  4  Current FSM state code.
REQ-013 halted  output  1  High while the FSM is in HALT.

Function
REQ-014 FSM states and codes SHALL be: INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.
REQ-015 INIT SHALL clear pc_out to 0 and IR to 0, then go to FETCH after 1 cycle.
REQ-016 FETCH SHALL load IR from instr_in, increment pc_out by 1, then go to DECODE.
REQ-017 pc_out SHALL wrap from 255 to 0.
REQ-018 DECODE SHALL select the next state from IR[15:12] as follows: 0 -> NOOP, 1 -> STORE, 2 -> LOAD_A, 3 -> ADD, 4 -> SUB, 5 -> HALT, 6..15 -> NOOP.
REQ-019 Each of NOOP, STORE, LOAD_B, ADD and SUB SHALL last 1 cycle and then return to FETCH.
REQ-020 LOAD_A SHALL go to LOAD_B unconditionally.
REQ-021 HALT SHALL be absorbing; it is exited only by rst_n.
REQ-022 Datapath control outputs SHALL be Moore decodes of state and IR; in every state not listed in REQ-023..REQ-026, D_wr, RF_W_en, RF_sel and ALU_s0 SHALL be 0.
REQ-023 STORE SHALL drive D_addr=IR[7:0], rdAddrA=IR[11:8], D_wr=1.
REQ-024 LOAD_A SHALL drive D_addr=IR[11:4], WriteAddr=IR[3:0], RF_sel=1, RF_W_en=0; this cycle covers the 1-cycle memory read latency.
REQ-025 LOAD_B SHALL drive the same address fields as LOAD_A, with RF_sel=1 and RF_W_en=1.
REQ-026 ADD/SUB SHALL drive rdAddrA=IR[11:8], rdAddrB=IR[7:4], WriteAddr=IR[3:0], RF_sel=0, RF_W_en=1, and ALU_s0=1 for ADD or 2 for SUB.
REQ-027 In states other than STORE, LOAD_A, LOAD_B, ADD and SUB, the address outputs SHALL hold the IR-derived fields given in REQ-023..REQ-026, with write enables off.
REQ-028 At most one of D_wr and RF_W_en SHALL be high in any cycle.
REQ-029 instr_in SHALL be sampled only in FETCH; changes to instr_in in any other state SHALL have no effect.
REQ-030 Cycle counts per instruction, including FETCH: NOOP/STORE/ADD/SUB/HALT-entry = 3 cycles, LOAD = 4 cycles.

Reset
REQ-031 On rst_n low, state SHALL go to INIT, and pc_out, IR, D_addr, address outputs, ALU_s0, D_wr, RF_W_en, RF_sel and halted SHALL go to 0 immediately, without waiting for clk.
REQ-032 Reset asserted mid-instruction (for example in LOAD_A or STORE) SHALL abort that instruction with no register or memory write; after release, execution SHALL restart from pc 0.

Configuration
REQ-033 With macro CU_SINGLE_STEP_EN defined, the block SHALL add input step (1 bit).
REQ-034 With CU_SINGLE_STEP_EN defined, FETCH SHALL hold (no IR load, no pc_out increment) until step is sampled high; one step pulse SHALL execute exactly one instruction, and a step held high SHALL behave as free-run.
REQ-035 With CU_SINGLE_STEP_EN undefined, the step port SHALL be absent and FETCH SHALL never stall.

Structure
REQ-036 Package cu_pkg SHALL hold the state enum, the opcode constants (OP_NOOP..OP_HALT) and the ALU select constants (ALU_PASS, ALU_ADD, ALU_SUB).
REQ-037 The program counter SHALL be a sub-module pc_counter with inputs clk, rst_n, clr and up, and output pc[7:0]; control_unit drives clr in INIT and up in FETCH.

Verification
REQ-038 The bench SHALL cover: reset release with instr_in=16'h3123 -> INIT, FETCH, DECODE, ADD; in ADD rdAddrA=1, rdAddrB=2, WriteAddr=3, ALU_s0=1, RF_W_en=1; pc_out=1.
REQ-039 The bench SHALL cover: instr 16'h2A57 -> LOAD_A with D_addr=8'hA5, RF_W_en=0; then LOAD_B with RF_sel=1, RF_W_en=1, WriteAddr=7; the instruction takes 4 cycles.
REQ-040 The bench SHALL cover: instr 16'h19C4 -> STORE with D_addr=8'hC4, rdAddrA=9, D_wr=1 for exactly 1 cycle.
REQ-041 The bench SHALL cover: instr 16'h5000 -> HALT with halted=1 held for 20 cycles and pc_out frozen; rst_n low then returns pc_out to 0.
REQ-042 The bench SHALL cover: rst_n asserted during LOAD_A -> all outputs 0 before the next edge, no RF_W_en pulse, restart in INIT.
REQ-043 The bench SHALL cover: forcing pc_out to 255 and then a NOOP (16'h0000) fetch -> pc_out=0; with CU_SINGLE_STEP_EN and step=0, FETCH holds for 10 cycles, and a single step pulse advances exactly one instruction.
